// File: rtl/mips_ex_wb_core.sv
// -----------------------------------------------------------------------------
// mips_ex_wb_core
//
// Execute/writeback core of the single-issue MIPS pipeline. One instruction per
// cycle is decoded, read from the 32x32 register file, executed and selected
// combinationally in EX. The result is captured into WB registers at the end of
// EX and committed to the register file at the end of the following cycle.
// Reads bypass the pending WB write, so dependent instructions can issue back
// to back without a stall. The core also owns HI/LO and the GPIO in/out path.
//
// Ports
//   clk      in   1  clock, all state on the rising edge
//   rst      in   1  asynchronous, active-high reset
//   instr    in  32  instruction in EX this cycle (0 = sll $0,$0,0 = NOP)
//   gpio_in  in  32  sampled at the end of a GPIO-IN EX cycle
//   gpio_out out 32  registered GPIO output, loaded by GPIO-OUT
// -----------------------------------------------------------------------------
module mips_ex_wb_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out
);

  // ---------------------------------------------------------------------------
  // Control types
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  // Second ALU operand: R[rt], sign-extended imm or zero-extended imm
  typedef enum logic [1:0] {
    SRC_RT, SRC_SEXT, SRC_ZEXT
  } alu_src_e;

  typedef enum logic [1:0] {
    RES_ALU, RES_HI, RES_LO, RES_GPIO
  } res_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    alu_src_e alu_src;
    logic     dst_rd;       // 1: destination is rd, 0: destination is rt
    logic     regwrite;
    logic     hilo_en;
    logic     mul_signed;   // mult vs multu
    res_sel_e res_sel;
    logic     gpio_out_en;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0][31:0] rf_q, rf_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       gpio_out_q, gpio_out_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;

  assign gpio_out = gpio_out_q;

  // ---------------------------------------------------------------------------
  // Decode (purely combinational). Anything unrecognised leaves every enable
  // low, which makes it a NOP with no architectural effect.
  // ---------------------------------------------------------------------------
  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    unique case (op)
      6'h00: begin
        ctrl.dst_rd = 1'b1;
        unique case (funct)
          6'h20, 6'h21: begin ctrl.alu_op = ALU_ADD;  ctrl.regwrite = 1'b1; end
          6'h22, 6'h23: begin ctrl.alu_op = ALU_SUB;  ctrl.regwrite = 1'b1; end
          6'h24:        begin ctrl.alu_op = ALU_AND;  ctrl.regwrite = 1'b1; end
          6'h25:        begin ctrl.alu_op = ALU_OR;   ctrl.regwrite = 1'b1; end
          6'h26:        begin ctrl.alu_op = ALU_XOR;  ctrl.regwrite = 1'b1; end
          6'h27:        begin ctrl.alu_op = ALU_NOR;  ctrl.regwrite = 1'b1; end
          6'h2A:        begin ctrl.alu_op = ALU_SLT;  ctrl.regwrite = 1'b1; end
          6'h2B:        begin ctrl.alu_op = ALU_SLTU; ctrl.regwrite = 1'b1; end
          6'h00:        begin ctrl.alu_op = ALU_SLL;  ctrl.regwrite = 1'b1; end
          6'h02:        begin ctrl.alu_op = ALU_SRL;  ctrl.regwrite = 1'b1; end
          6'h03:        begin ctrl.alu_op = ALU_SRA;  ctrl.regwrite = 1'b1; end
          6'h18:        begin ctrl.hilo_en = 1'b1; ctrl.mul_signed = 1'b1; end
          6'h19:        begin ctrl.hilo_en = 1'b1; end
          6'h10:        begin ctrl.res_sel = RES_HI; ctrl.regwrite = 1'b1; end
          6'h12:        begin ctrl.res_sel = RES_LO; ctrl.regwrite = 1'b1; end
          default:      ctrl.dst_rd = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin ctrl.alu_op = ALU_ADD;  ctrl.alu_src = SRC_SEXT; ctrl.regwrite = 1'b1; end
      6'h0A:        begin ctrl.alu_op = ALU_SLT;  ctrl.alu_src = SRC_SEXT; ctrl.regwrite = 1'b1; end
      6'h0B:        begin ctrl.alu_op = ALU_SLTU; ctrl.alu_src = SRC_SEXT; ctrl.regwrite = 1'b1; end
      6'h0C:        begin ctrl.alu_op = ALU_AND;  ctrl.alu_src = SRC_ZEXT; ctrl.regwrite = 1'b1; end
      6'h0D:        begin ctrl.alu_op = ALU_OR;   ctrl.alu_src = SRC_ZEXT; ctrl.regwrite = 1'b1; end
      6'h0E:        begin ctrl.alu_op = ALU_XOR;  ctrl.alu_src = SRC_ZEXT; ctrl.regwrite = 1'b1; end
      6'h0F:        begin ctrl.alu_op = ALU_LUI;  ctrl.alu_src = SRC_ZEXT; ctrl.regwrite = 1'b1; end
      6'h1C: begin
        unique case (funct)
          6'h00:   begin ctrl.res_sel = RES_GPIO; ctrl.regwrite = 1'b1; end
          6'h01:   ctrl.gpio_out_en = 1'b1;
          default: ctrl.gpio_out_en = 1'b0;
        endcase
      end
      default: ctrl.regwrite = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register read with write-through bypass from the WB stage. $0 is forced
  // to zero here so a stray bypass match on address 0 can never leak data.
  // ---------------------------------------------------------------------------
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    rs_val = rf_q[rs];
    if (wb_we_q && (wb_waddr_q == rs)) rs_val = wb_wdata_q;
    if (rs == 5'd0) rs_val = '0;

    rt_val = rf_q[rt];
    if (wb_we_q && (wb_waddr_q == rt)) rt_val = wb_wdata_q;
    if (rt == 5'd0) rt_val = '0;
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        unused_alu_zero;

  always_comb begin
    unique case (ctrl.alu_src)
      SRC_SEXT: alu_b = {{16{imm[15]}}, imm};
      SRC_ZEXT: alu_b = {16'h0000, imm};
      default:  alu_b = rt_val;
    endcase
  end

  always_comb begin
    unique case (ctrl.alu_op)
      ALU_ADD:  alu_res = rs_val + alu_b;
      ALU_SUB:  alu_res = rs_val - alu_b;
      ALU_AND:  alu_res = rs_val & alu_b;
      ALU_OR:   alu_res = rs_val | alu_b;
      ALU_XOR:  alu_res = rs_val ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_val | alu_b);
      ALU_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, rs_val < alu_b};
      ALU_SLL:  alu_res = alu_b << shamt;
      ALU_SRL:  alu_res = alu_b >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_res = {alu_b[15:0], 16'h0000};
      default:  alu_res = '0;
    endcase
  end

  // Zero flag exists for visibility only; nothing architectural consumes it.
  assign alu_zero        = (alu_res == 32'd0);
  assign unused_alu_zero = alu_zero;

  // ---------------------------------------------------------------------------
  // Multiplier. Operands are extended to 64 bits (sign or zero per mult/multu);
  // the low 64 bits of that product equal the true 64-bit result either way.
  // ---------------------------------------------------------------------------
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_p;

  assign mul_a = {{32{ctrl.mul_signed & rs_val[31]}}, rs_val};
  assign mul_b = {{32{ctrl.mul_signed & rt_val[31]}}, rt_val};
  assign mul_p = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Result select and next-state logic
  // ---------------------------------------------------------------------------
  logic [31:0] result;

  always_comb begin
    unique case (ctrl.res_sel)
      RES_HI:   result = hi_q;
      RES_LO:   result = lo_q;
      RES_GPIO: result = gpio_in;
      default:  result = alu_res;
    endcase
  end

  always_comb begin
    wb_we_d    = ctrl.regwrite;
    wb_waddr_d = ctrl.dst_rd ? rd : rt;
    wb_wdata_d = result;

    hi_d = hi_q;
    lo_d = lo_q;
    if (ctrl.hilo_en) begin
      hi_d = mul_p[63:32];
      lo_d = mul_p[31:0];
    end

    // rt_val already carries the bypass, so GPIO-OUT sees the previous result
    gpio_out_d = ctrl.gpio_out_en ? rt_val : gpio_out_q;

    rf_d = rf_q;
    if (wb_we_q && (wb_waddr_q != 5'd0)) rf_d[wb_waddr_q] = wb_wdata_q;
    rf_d[0] = '0;
  end

  // ---------------------------------------------------------------------------
  // Flops. Reset clears WB regwrite so an in-flight writeback is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      gpio_out_q <= '0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      rf_q       <= rf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      gpio_out_q <= gpio_out_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

endmodule

// File: tb/tb_mips_ex_wb_core.sv
module tb_mips_ex_wb_core;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;

  int errors = 0;
  int checks = 0;

  mips_ex_wb_core dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus record: instruction, gpio_in value, whether to check gpio_out
  // after this cycle's edge, and the required gpio_out.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] gin;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          id_q[$];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] gout(input logic [4:0] rt);
    return itype(6'h1C, 5'd0, rt, 16'h0001);
  endfunction

  function automatic logic [31:0] gin(input logic [4:0] rt);
    return itype(6'h1C, 5'd0, rt, 16'h0000);
  endfunction

  task automatic add(input logic [31:0] i, input logic [31:0] g, input bit c,
                     input logic [31:0] e);
    vec_t v;
    v.ins = i; v.gin = g; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one instruction for one cycle; the expected gpio_out is queued at
  // drive time and compared once the edge that ends the EX cycle has passed.
  task automatic step(input logic [31:0] i, input logic [31:0] g, input bit c,
                      input logic [31:0] e, input int id);
    logic [31:0] want;
    int          wid;
    instr   = i;
    gpio_in = g;
    if (c) begin
      exp_q.push_back(e);
      id_q.push_back(id);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      wid  = id_q.pop_front();
      checks++;
      if (gpio_out !== want) begin
        errors++;
        $display("FAIL gpio_out step %0d: got %h want %h", wid, gpio_out, want);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    instr   = '0;
    gpio_in = '0;
    #2;
    check("reset gpio_out", gpio_out, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Forwarding chain
    add(itype(6'h08, 5'd0, 5'd1, 16'h7FFF), 0, 0, 0);
    add(itype(6'h08, 5'd1, 5'd1, 16'h0001), 0, 0, 0);
    add(rtype(5'd0, 5'd1, 5'd2, 5'd4, 6'h00), 0, 0, 0);
    add(gout(5'd2), 0, 1, 32'h0008_0000);
    add(32'h0, 0, 1, 32'h0008_0000);                       // gpio_out holds
    // Sign / zero extension and compares
    add(itype(6'h08, 5'd0, 5'd3, 16'hFFFF), 0, 0, 0);
    add(itype(6'h0D, 5'd0, 5'd4, 16'hFFFF), 0, 0, 0);
    add(gout(5'd3), 0, 1, 32'hFFFF_FFFF);
    add(gout(5'd4), 0, 1, 32'h0000_FFFF);
    add(rtype(5'd3, 5'd4, 5'd5, 5'd0, 6'h2A), 0, 0, 0);
    add(gout(5'd5), 0, 1, 32'h1);
    add(rtype(5'd3, 5'd4, 5'd6, 5'd0, 6'h2B), 0, 0, 0);
    add(gout(5'd6), 0, 1, 32'h0);
    add(itype(6'h0F, 5'd0, 5'd7, 16'h1234), 0, 0, 0);
    add(gout(5'd7), 0, 1, 32'h1234_0000);
    // Multiply, mfhi/mflo right after
    add(itype(6'h08, 5'd0, 5'd8, 16'h0002), 0, 0, 0);
    add(rtype(5'd3, 5'd8, 5'd0, 5'd0, 6'h18), 0, 0, 0);
    add(rtype(5'd0, 5'd0, 5'd9, 5'd0, 6'h10), 0, 0, 0);
    add(gout(5'd9), 0, 1, 32'hFFFF_FFFF);
    add(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h12), 0, 0, 0);
    add(gout(5'd10), 0, 1, 32'hFFFF_FFFE);
    add(rtype(5'd3, 5'd8, 5'd0, 5'd0, 6'h19), 0, 0, 0);
    add(rtype(5'd0, 5'd0, 5'd9, 5'd0, 6'h10), 0, 0, 0);
    add(gout(5'd9), 0, 1, 32'h1);
    add(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h12), 0, 0, 0);
    add(gout(5'd10), 0, 1, 32'hFFFF_FFFE);
    // GPIO loop; gpio_in changes after the sampling edge
    add(gin(5'd11), 32'hA5A5_A5A5, 0, 0);
    add(itype(6'h0E, 5'd11, 5'd11, 16'hFFFF), 32'h1111_1111, 0, 0);
    add(gout(5'd11), 32'h2222_2222, 1, 32'hA5A5_5A5A);
    // $0 protection
    add(itype(6'h08, 5'd0, 5'd0, 16'h0009), 0, 0, 0);
    add(gout(5'd0), 0, 1, 32'h0);
    // Shifts
    add(itype(6'h0F, 5'd0, 5'd12, 16'h8000), 0, 0, 0);
    add(rtype(5'd0, 5'd12, 5'd13, 5'd4, 6'h03), 0, 0, 0);
    add(gout(5'd13), 0, 1, 32'hF800_0000);
    add(rtype(5'd0, 5'd12, 5'd14, 5'd4, 6'h02), 0, 0, 0);
    add(gout(5'd14), 0, 1, 32'h0800_0000);
    // Remaining ALU ops
    add(rtype(5'd3, 5'd8, 5'd15, 5'd0, 6'h21), 0, 0, 0);
    add(gout(5'd15), 0, 1, 32'h1);
    add(rtype(5'd8, 5'd3, 5'd16, 5'd0, 6'h22), 0, 0, 0);
    add(gout(5'd16), 0, 1, 32'h3);
    add(rtype(5'd12, 5'd3, 5'd17, 5'd0, 6'h24), 0, 0, 0);
    add(gout(5'd17), 0, 1, 32'h8000_0000);
    add(rtype(5'd4, 5'd0, 5'd18, 5'd0, 6'h27), 0, 0, 0);
    add(gout(5'd18), 0, 1, 32'hFFFF_0000);
    add(rtype(5'd3, 5'd4, 5'd19, 5'd0, 6'h26), 0, 0, 0);
    add(gout(5'd19), 0, 1, 32'hFFFF_0000);
    add(rtype(5'd12, 5'd4, 5'd20, 5'd0, 6'h25), 0, 0, 0);
    add(gout(5'd20), 0, 1, 32'h8000_FFFF);
    add(itype(6'h0A, 5'd3, 5'd21, 16'h0000), 0, 0, 0);
    add(gout(5'd21), 0, 1, 32'h1);
    add(itype(6'h0B, 5'd4, 5'd22, 16'hFFFF), 0, 0, 0);
    add(gout(5'd22), 0, 1, 32'h1);
    add(itype(6'h0C, 5'd3, 5'd23, 16'h8001), 0, 0, 0);
    add(gout(5'd23), 0, 1, 32'h0000_8001);
    add(itype(6'h09, 5'd4, 5'd24, 16'h8000), 0, 0, 0);
    add(gout(5'd24), 0, 1, 32'h0000_7FFF);
    // Undefined encodings are NOPs
    add(itype(6'h3F, 5'd0, 5'd24, 16'h1234), 0, 1, 32'h0000_7FFF);
    add(rtype(5'd3, 5'd3, 5'd24, 5'd0, 6'h01), 0, 0, 0);
    add(itype(6'h1C, 5'd0, 5'd24, 16'h0002), 32'hDEAD_BEEF, 1, 32'h0000_7FFF);
    add(gout(5'd24), 0, 1, 32'h0000_7FFF);

    foreach (vecs[k]) step(vecs[k].ins, vecs[k].gin, vecs[k].chk, vecs[k].exp, k);

    // Reset mid-run with a writeback in flight
    step(itype(6'h08, 5'd0, 5'd1, 16'h0005), 0, 0, 0, 1000);
    step(itype(6'h08, 5'd0, 5'd25, 16'h0007), 0, 0, 0, 1001);
    step(rtype(5'd1, 5'd25, 5'd0, 5'd0, 6'h18), 0, 0, 0, 1002);
    step(gout(5'd1), 0, 1, 32'h5, 1003);
    step(itype(6'h08, 5'd0, 5'd2, 16'h0009), 0, 0, 0, 1004);
    instr = '0;
    #2 rst = 1'b1;
    #1;
    check("async reset gpio_out", gpio_out, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(gout(5'd2), 0, 1, 32'h0, 1005);                  // pending write dropped
    step(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1006);
    step(gout(5'd2), 0, 1, 32'h0, 1007);                  // LO cleared
    step(gout(5'd1), 0, 1, 32'h0, 1008);
    step(gout(5'd25), 0, 1, 32'h0, 1009);
    // First instruction after reset executes normally
    step(itype(6'h08, 5'd0, 5'd26, 16'h0042), 0, 0, 0, 1010);
    step(gout(5'd26), 0, 1, 32'h42, 1011);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_ex_wb_core.md
# mips_ex_wb_core

Execute/writeback core of the single-issue MIPS pipeline. It takes one 32-bit instruction per cycle from the fetch stage and decodes it. It reads the 32×32 register file, computes the result in the ALU and writes it back one cycle later. It also owns the HI/LO registers and the memory-mapped GPIO in/out path.

## Interface
- No parameters.
- clk  input  1  clock, all state rising-edge.
- rst  input  1  reset rst, asynchronous, active-high.
- instr  input  32  instruction in EX this cycle; 0 (sll $0,$0,0) acts as NOP.
- gpio_in  input  32  sampled by GPIO-IN instruction.
- gpio_out  output  32  registered GPIO output.

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- A = R[rs], B = R[rt] (R-type) or imm extended. Sign-extend for addi, addiu, slti, sltiu; zero-extend for andi, ori, xori.
- R-type (op=0), destination rd:
  - add 20, addu 21, sub 22, subu 23: 32-bit wrap; overflow is ignored, no trap.
  - and 24, or 25, xor 26, nor 27.
  - slt 2A is signed; sltu 2B is unsigned. Result is 1 or 0.
  - sll 00, srl 02, sra 03: shift B by shamt.
  - mult 18 (signed) and multu 19 (unsigned) form a 64-bit product, {HI,LO} ← product. No register write.
  - mfhi 10: R[rd] ← HI. mflo 12: R[rd] ← LO.
- I-type, destination rt:
  - addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E.
  - lui 0F: (zero-extended imm) << 16.
- GPIO, op=1C, no ALU use:
  - funct 00 (GPIO-IN): R[rt] ← gpio_in.
  - funct 01 (GPIO-OUT): gpio_out ← R[rt].
- Any other op/funct: NOP, with no architectural state change.
- Register $0 reads 0 always. Writes to $0 are discarded.
- ALU zero flag = (result==0). It is internal only, not used architecturally.
- Control decode is purely combinational from instr. It produces alu_op, alu_src (rt/sign/zero), rd-vs-rt select, regwrite, hilo_en, result select (ALU/HI/LO/gpio_in) and gpio_out_en.

## Timing
- Cycle N, EX: decode, register read, ALU and result select are all combinational from instr.
- Edge ending N:
  - WB registers capture regwrite, writeaddr and writedata.
  - HI/LO update if mult/multu.
  - gpio_out updates if GPIO-OUT.
- Cycle N+1, WB: the regfile writes on the edge ending N+1.
- Regfile is write-through. If WB write is enabled, waddr==raddr and raddr≠0, then readdata = WB writedata in that cycle. Back-to-back dependent instructions therefore need no stall.
- mfhi/mflo immediately after mult sees the new HI/LO, because HI/LO are written at the end of the mult's EX cycle.
- GPIO-OUT reads R[rt] with the same write-through bypass, so the value produced by the previous instruction is output.
- gpio_in is sampled at the edge ending the GPIO-IN EX cycle.
- Reset, asynchronous, any time:
  - all 31 registers, HI, LO, gpio_out and the WB writedata/writeaddr go to 0.
  - WB regwrite goes to 0, so a pending writeback is cancelled.
  - After release, the first instruction executes normally.

## Test plan
- Reset mid-run: load $1=5 via addi, assert rst for 1 cycle, then execute mflo $2 and GPIO-OUT $1. Required: gpio_out=0 after reset, $2=0, then gpio_out=0 since $1=0.
- Back-to-back forwarding: addi $1,$0,0x7FFF; addi $1,$1,1; sll $2,$1,4; GPIO-OUT $2. Required: gpio_out=0x00080000 one edge after the GPIO-OUT cycle.
- Sign/zero extension: addi $3,$0,-1 gives 0xFFFFFFFF. ori $4,$0,0xFFFF gives 0x0000FFFF. slt $5,$3,$4 gives 1. sltu $6,$3,$4 gives 0. lui $7,0x1234 gives 0x12340000.
- Multiply: $3=0xFFFFFFFF, $8=2. mult $3,$8 then mfhi $9, mflo $10 gives $9=0xFFFFFFFF, $10=0xFFFFFFFE. multu gives $9=1, $10=0xFFFFFFFE.
- GPIO loop: gpio_in=0xA5A5A5A5; GPIO-IN $11; xori $11,$11,0xFFFF; GPIO-OUT $11. Required: gpio_out=0xA5A55A5A.
- $0 protection and shifts: addi $0,$0,9 then GPIO-OUT $0 gives 0. $12=0x80000000: sra by 4 gives 0xF8000000, srl by 4 gives 0x08000000.
